// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard sequencer (slave).
// Carries the ID instruction fields, redirect/memory status, stage controls, bypass selects and counters.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic [4:0]       id_wreg;
   logic             id_regwrite;
   logic             id_memread;
   logic             branch_miss;
   logic             dmem_req;
   logic             dmem_ready;
   logic             pc_keep;
   logic             ifid_keep;
   logic             ifid_flush;
   logic             idex_nop;
   logic             exmem_keep;
   logic [1:0]       fwd_ex_pyc;
   logic [1:0]       fwd_mem_pyc;
   logic [1:0]       fwd_load_pyc;
   logic [1:0]       fwd_hazard_pyc;
   logic [CNT_W-1:0] cnt_load_stall;
   logic [CNT_W-1:0] cnt_mem_wait;
   logic [CNT_W-1:0] cnt_flush;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wreg, id_regwrite,
             id_memread, branch_miss, dmem_req, dmem_ready,
      input  pc_keep, ifid_keep, ifid_flush, idex_nop, exmem_keep,
             fwd_ex_pyc, fwd_mem_pyc, fwd_load_pyc, fwd_hazard_pyc,
             cnt_load_stall, cnt_mem_wait, cnt_flush
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_wreg, id_regwrite,
             id_memread, branch_miss, dmem_req, dmem_ready,
      output pc_keep, ifid_keep, ifid_flush, idex_nop, exmem_keep,
             fwd_ex_pyc, fwd_mem_pyc, fwd_load_pyc, fwd_hazard_pyc,
             cnt_load_stall, cnt_mem_wait, cnt_flush
   );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline sequencer: stage keep/flush/nop controls (same cycle), registered bypass selects
// (one cycle), per-cause stall counters. A data-memory wait freezes everything and overrides redirects.
module hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave bus
);

   typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

   typedef struct packed {
      logic       valid;
      logic [4:0] wreg;
      logic       regwrite;
      logic       memread;
   } shadow_t;

   state_t           state, state_nxt;
   shadow_t          p1, p2, p3, id_ins;
   logic             frozen, flush, stall, nop, load_use;
   logic [3:0]       sel_rs1, sel_rs2;
   logic [1:0]       fwd_ex, fwd_mem, fwd_load, fwd_hz;
   logic [CNT_W-1:0] cnt_ld, cnt_mw, cnt_fl;

   function automatic logic hit(input shadow_t p, input logic [4:0] r);
      return p.valid && p.regwrite && (p.wreg == r);
   endfunction

   // Returns {ex, mem, load, hazard}; a load one stage ahead is left to the load-use bubble.
   function automatic logic [3:0] fwd_sel(input logic [4:0] r, input logic used,
                                          input shadow_t a, input shadow_t b, input shadow_t c);
      logic [3:0] s;
      s = 4'b0000;
      if (used && (r != 5'd0)) begin
         if (hit(a, r))      s = a.memread ? 4'b0000 : 4'b1000;
         else if (hit(b, r)) s = b.memread ? 4'b0010 : 4'b0100;
         else if (hit(c, r)) s = 4'b0001;
      end
      return s;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && !(&v)) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
   endfunction

   assign id_ins   = '{valid: bus.id_valid, wreg: bus.id_wreg,
                       regwrite: bus.id_regwrite, memread: bus.id_memread};
   assign load_use = bus.id_valid && p1.valid && p1.memread && (p1.wreg != 5'd0) &&
                     ((bus.id_use_rs1 && (bus.id_rs1 == p1.wreg)) ||
                      (bus.id_use_rs2 && (bus.id_rs2 == p1.wreg)));
   assign sel_rs1  = fwd_sel(bus.id_rs1, bus.id_valid && bus.id_use_rs1, p1, p2, p3);
   assign sel_rs2  = fwd_sel(bus.id_rs2, bus.id_valid && bus.id_use_rs2, p1, p2, p3);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_RUN;
      else      state <= state_nxt;
   end

   // The cycle in which a waited access completes advances normally, so a held redirect acts then.
   always_comb begin
      state_nxt       = state;
      frozen          = 1'b0;
      flush           = 1'b0;
      stall           = 1'b0;
      nop             = 1'b0;
      bus.pc_keep     = 1'b0;
      bus.ifid_keep   = 1'b0;
      bus.ifid_flush  = 1'b0;
      bus.idex_nop    = 1'b0;
      bus.exmem_keep  = 1'b0;
      case (state)
         ST_RUN: begin
            if (bus.dmem_req && !bus.dmem_ready) begin
               frozen    = 1'b1;
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.dmem_ready) state_nxt = ST_RUN;
            else                frozen    = 1'b1;
         end
         default: state_nxt = ST_RUN;
      endcase
      flush = !frozen && bus.branch_miss;
      stall = !frozen && !bus.branch_miss && load_use;
      nop   = flush || stall;
      if (rst) begin
         bus.pc_keep    = frozen || stall;
         bus.ifid_keep  = frozen || stall;
         bus.ifid_flush = flush;
         bus.idex_nop   = nop;
         bus.exmem_keep = frozen;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p1       <= '0;
         p2       <= '0;
         p3       <= '0;
         fwd_ex   <= 2'b00;
         fwd_mem  <= 2'b00;
         fwd_load <= 2'b00;
         fwd_hz   <= 2'b00;
         cnt_ld   <= '0;
         cnt_mw   <= '0;
         cnt_fl   <= '0;
      end else begin
         if (!frozen) begin
            p3       <= p2;
            p2       <= p1;
            p1       <= nop ? shadow_t'('0) : id_ins;
            fwd_ex   <= nop ? 2'b00 : {sel_rs1[3], sel_rs2[3]};
            fwd_mem  <= nop ? 2'b00 : {sel_rs1[2], sel_rs2[2]};
            fwd_load <= nop ? 2'b00 : {sel_rs1[1], sel_rs2[1]};
            fwd_hz   <= nop ? 2'b00 : {sel_rs1[0], sel_rs2[0]};
         end
         cnt_ld <= sat_inc(cnt_ld, stall);
         cnt_mw <= sat_inc(cnt_mw, frozen);
         cnt_fl <= sat_inc(cnt_fl, flush);
      end
   end

   assign bus.fwd_ex_pyc     = fwd_ex;
   assign bus.fwd_mem_pyc    = fwd_mem;
   assign bus.fwd_load_pyc   = fwd_load;
   assign bus.fwd_hazard_pyc = fwd_hz;
   assign bus.cnt_load_stall = cnt_ld;
   assign bus.cnt_mem_wait   = cnt_mw;
   assign bus.cnt_flush      = cnt_fl;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table for the instruction-stream cases, hand sequences for memory
// wait and reset, then random traffic against a distance-based reference model.
module tb_hazard_ctrl;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   hazard_ctrl_if #(.CNT_W(32)) bus ();
   hazard_ctrl #(.CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl = {pc_keep, ifid_keep, ifid_flush, idex_nop, exmem_keep}; fwd = {ex, mem, load, hazard}
   typedef struct {
      logic       vld;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] wd;
      logic       rw;
      logic       mr;
      logic       br;
      logic       req;
      logic       rdy;
      logic [4:0] ctl;
      logic [7:0] fwd;
   } vec_t;

   typedef struct {
      logic       v;
      logic [4:0] wd;
      logic       rw;
      logic       mr;
   } slot_t;

   localparam logic [4:0] C0 = 5'b00000;
   localparam logic [4:0] CS = 5'b11010;
   localparam logic [4:0] CB = 5'b00110;
   localparam logic [4:0] CW = 5'b11001;

   vec_t tbl[18];

   function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] wd,
                               input logic rw, input logic mr, input logic br, input logic req,
                               input logic rdy, input logic [4:0] ctl, input logic [7:0] fwd);
      vec_t v;
      v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.wd = wd;
      v.rw = rw; v.mr = mr; v.br = br; v.req = req; v.rdy = rdy; v.ctl = ctl; v.fwd = fwd;
      return v;
   endfunction

   function automatic vec_t nopv(input logic br, input logic req, input logic rdy,
                                 input logic [4:0] ctl, input logic [7:0] fwd);
      return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, br, req, rdy, ctl, fwd);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] ctl_now();
      return {bus.pc_keep, bus.ifid_keep, bus.ifid_flush, bus.idex_nop, bus.exmem_keep};
   endfunction

   function automatic logic [7:0] fwd_now();
      return {bus.fwd_ex_pyc, bus.fwd_mem_pyc, bus.fwd_load_pyc, bus.fwd_hazard_pyc};
   endfunction

   task automatic drive(input vec_t v);
      bus.id_valid    = v.vld;
      bus.id_rs1      = v.rs1;
      bus.id_rs2      = v.rs2;
      bus.id_use_rs1  = v.u1;
      bus.id_use_rs2  = v.u2;
      bus.id_wreg     = v.wd;
      bus.id_regwrite = v.rw;
      bus.id_memread  = v.mr;
      bus.branch_miss = v.br;
      bus.dmem_req    = v.req;
      bus.dmem_ready  = v.rdy;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      chk($sformatf("%s_ctl", tag), 32'(ctl_now()), 32'(v.ctl));
      chk($sformatf("%s_fwd", tag), 32'(fwd_now()), 32'(v.fwd));
   endtask

   task automatic chk_cnt(input string tag, input int ld, input int mw, input int fl);
      chk($sformatf("%s_cnt_load_stall", tag), bus.cnt_load_stall, 32'(ld));
      chk($sformatf("%s_cnt_mem_wait", tag), bus.cnt_mem_wait, 32'(mw));
      chk($sformatf("%s_cnt_flush", tag), bus.cnt_flush, 32'(fl));
   endtask

   // Reference: hist[d] is the instruction issued d+1 slots before the one now in ID.
   task automatic random_run(input int cycles);
      slot_t       hist[3];
      logic        m_wait, frozen, lu, nop, found;
      logic [7:0]  m_fwd, nf;
      logic [4:0]  r, ectl;
      logic        used;
      int          m_ld, m_mw, m_fl, k;
      vec_t        v;
      for (int d = 0; d < 3; d++) hist[d] = '{1'b0, 5'd0, 1'b0, 1'b0};
      m_wait = 1'b0; m_fwd = 8'h00; m_ld = 0; m_mw = 0; m_fl = 0;
      for (int c = 0; c < cycles; c++) begin
         v = mk($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0, 1'($urandom), C0, 8'h00);
         frozen = (m_wait || v.req) && !v.rdy;
         lu = 1'b0;
         for (int s = 0; s < 2; s++) begin
            r    = (s == 0) ? v.rs1 : v.rs2;
            used = (s == 0) ? v.u1 : v.u2;
            if (v.vld && used && r != 0 && hist[0].v && hist[0].mr && hist[0].wd == r) lu = 1'b1;
         end
         if (frozen)    ectl = CW;
         else if (v.br) ectl = CB;
         else if (lu)   ectl = CS;
         else           ectl = C0;
         @(posedge clk);
         #1;
         drive(v);
         @(negedge clk);
         chk("rnd_ctl", 32'(ctl_now()), 32'(ectl));
         chk("rnd_fwd", 32'(fwd_now()), 32'(m_fwd));
         chk_cnt("rnd", m_ld, m_mw, m_fl);
         m_wait = frozen;
         if (frozen) m_mw++;
         else begin
            nop = v.br || lu;
            if (v.br) m_fl++;
            else if (lu) m_ld++;
            nf = 8'h00;
            if (!nop && v.vld) begin
               for (int s = 0; s < 2; s++) begin
                  r     = (s == 0) ? v.rs1 : v.rs2;
                  used  = (s == 0) ? v.u1 : v.u2;
                  found = 1'b0;
                  for (int d = 0; d < 3; d++) begin
                     if (!found && used && r != 0 && hist[d].v && hist[d].rw && hist[d].wd == r) begin
                        found = 1'b1;
                        k = -1;
                        if (d == 0)      k = hist[d].mr ? -1 : 3;
                        else if (d == 1) k = hist[d].mr ? 1 : 2;
                        else             k = 0;
                        if (k >= 0) nf[k * 2 + ((s == 0) ? 1 : 0)] = 1'b1;
                     end
                  end
               end
            end
            m_fwd   = nf;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = nop ? '{1'b0, 5'd0, 1'b0, 1'b0} : '{v.vld, v.wd, v.rw, v.mr};
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b0;
      drive(nopv(1'b0, 1'b1, 1'b0, C0, 8'h00));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", 32'(ctl_now()), 32'(C0));
      chk("reset_fwd", 32'(fwd_now()), 32'(8'h00));
      chk_cnt("reset", 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(nopv(1'b0, 1'b0, 1'b0, C0, 8'h00));

      //            vld  rs1    rs2    u1 u2 wd     rw mr  br req rdy ctl  fwd
      tbl[0]  = mk(1, 5'd1,  5'd0,  1, 0, 5'd5,  1, 1,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[1]  = mk(1, 5'd5,  5'd1,  1, 1, 5'd6,  1, 0,  0, 0, 0, CS, 8'b00_00_00_00);
      tbl[2]  = mk(1, 5'd5,  5'd1,  1, 1, 5'd6,  1, 0,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[3]  = mk(1, 5'd0,  5'd0,  1, 0, 5'd3,  1, 0,  0, 0, 0, C0, 8'b00_00_10_00);
      tbl[4]  = mk(1, 5'd1,  5'd3,  1, 1, 5'd4,  1, 0,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[5]  = mk(1, 5'd1,  5'd3,  1, 1, 5'd8,  1, 0,  0, 0, 0, C0, 8'b01_00_00_00);
      tbl[6]  = mk(1, 5'd1,  5'd3,  1, 1, 5'd9,  1, 0,  0, 0, 0, C0, 8'b00_01_00_00);
      tbl[7]  = mk(1, 5'd0,  5'd0,  1, 0, 5'd0,  1, 0,  0, 0, 0, C0, 8'b00_00_00_01);
      tbl[8]  = mk(1, 5'd0,  5'd0,  1, 1, 5'd7,  1, 0,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[9]  = mk(1, 5'd7,  5'd9,  1, 1, 5'd10, 1, 0,  1, 0, 0, CB, 8'b00_00_00_00);
      tbl[10] = mk(1, 5'd7,  5'd7,  1, 1, 5'd11, 1, 0,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[11] = nopv(0, 0, 0, C0, 8'b00_11_00_00);
      tbl[12] = mk(1, 5'd11, 5'd0,  1, 0, 5'd12, 1, 1,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[13] = mk(1, 5'd1,  5'd12, 1, 0, 5'd13, 1, 0,  0, 0, 0, C0, 8'b00_10_00_00);
      tbl[14] = mk(1, 5'd1,  5'd0,  1, 0, 5'd14, 1, 1,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[15] = mk(1, 5'd1,  5'd14, 1, 1, 5'd15, 1, 0,  0, 0, 0, CS, 8'b00_00_00_00);
      tbl[16] = mk(1, 5'd1,  5'd14, 1, 1, 5'd15, 1, 0,  0, 0, 0, C0, 8'b00_00_00_00);
      tbl[17] = nopv(0, 0, 0, C0, 8'b00_00_01_00);
      for (int i = 0; i < 18; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));
      chk_cnt("tbl_end", 2, 0, 1);

      // Memory wait with a redirect raised during the freeze.
      run_vec(mk(1, 5'd0, 5'd0, 1, 0, 5'd20, 1, 0, 0, 0, 0, C0, 8'h00), "w0");
      run_vec(mk(1, 5'd20, 5'd0, 1, 1, 5'd21, 1, 0, 0, 0, 0, C0, 8'h00), "w1");
      run_vec(mk(1, 5'd1, 5'd21, 1, 1, 5'd0, 0, 0, 0, 1, 0, CW, 8'b10_00_00_00), "w2");
      run_vec(mk(1, 5'd1, 5'd21, 1, 1, 5'd0, 0, 0, 1, 1, 0, CW, 8'b10_00_00_00), "w3");
      run_vec(mk(1, 5'd1, 5'd21, 1, 1, 5'd0, 0, 0, 1, 1, 0, CW, 8'b10_00_00_00), "w4");
      run_vec(mk(1, 5'd1, 5'd21, 1, 1, 5'd0, 0, 0, 1, 1, 1, CB, 8'b10_00_00_00), "w5");
      run_vec(nopv(0, 0, 0, C0, 8'h00), "w6");
      chk_cnt("wait_end", 2, 3, 2);

      // Reset asserted while frozen in WAIT.
      run_vec(nopv(0, 1, 0, CW, 8'h00), "r0");
      run_vec(nopv(0, 1, 0, CW, 8'h00), "r1");
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wait_ctl", 32'(ctl_now()), 32'(C0));
      chk("rst_wait_fwd", 32'(fwd_now()), 32'(8'h00));
      chk_cnt("rst_wait", 0, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(nopv(1, 0, 0, C0, 8'h00));
      @(negedge clk);
      chk("rst_run_ctl", 32'(ctl_now()), 32'(CB));
      run_vec(mk(1, 5'd20, 5'd21, 1, 1, 5'd22, 1, 0, 0, 0, 0, C0, 8'h00), "r3");
      run_vec(nopv(0, 0, 0, C0, 8'h00), "r4");
      chk_cnt("rst_after", 0, 0, 1);

      // Fresh start for the random phase so the model begins from the reset state.
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(nopv(0, 0, 0, C0, 8'h00));
      @(posedge clk);
      #1;
      rst = 1'b1;
      random_run(600);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
